uart_tx_serializer: RTL and testbench

Byte-to-serial UART transmitter that sits directly downstream of the Wishbone UART TX slave. It takes the byte and level-held valid strobe the slave drives for the length of a bus write, queues the byte in a small FIFO, and shifts it out as 8N1 frames on the TX pin. It returns a one-cycle `transmission_done_o` pulse per frame.

---
 rtl/uart_tx_serializer_pkg.sv | 18 +
 rtl/uart_tx_serializer_if.sv | 22 ++
 rtl/uart_tx_serializer_byte_fifo.sv | 64 ++++++
 rtl/uart_tx_serializer.sv | 134 +++++++++++++
 tb/tb_uart_tx_serializer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_serializer_pkg.sv
// uart_pkg: shared types and constants for the UART TX serializer slice.
//   tx_state_e      - transmitter FSM state encoding
//   UART_DATA_BITS  - data bits per frame (8N1)
//   UART_LINE_IDLE  - line level for idle and stop bit
package uart_pkg;

   localparam int   UART_DATA_BITS = 8;
   localparam logic UART_LINE_IDLE = 1'b1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      DONE  = 3'd4
   } tx_state_e;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// uart_tx_serializer_if: byte request path from the Wishbone TX slave into
// the serializer, plus the FIFO status fed back to the slave.
//   tx_data       - byte to send
//   tx_data_valid - level request, one byte per high period
//   fifo_full     - FIFO holds FIFO_DEPTH bytes
//   fifo_empty    - FIFO holds no bytes
//   overflow      - one-cycle pulse when a request was dropped
interface uart_tx_serializer_if;

   logic [uart_pkg::UART_DATA_BITS-1:0] tx_data;
   logic                                tx_data_valid;
   logic                                fifo_full;
   logic                                fifo_empty;
   logic                                overflow;

   modport master (output tx_data, tx_data_valid,
                   input  fifo_full, fifo_empty, overflow);

   modport slave  (input  tx_data, tx_data_valid,
                   output fifo_full, fifo_empty, overflow);

endinterface

// File: rtl/uart_tx_serializer_byte_fifo.sv
// byte_fifo: synchronous FIFO, power-of-2 depth, head shown combinationally.
//   clk_i, rst_i  - clock, async active-low reset
//   push_i, din_i - write request and data
//   pop_i, dout_o - read request and head data
//   full_o        - registered, count == DEPTH after this cycle
//   empty_o       - registered, count == 0 after this cycle
module byte_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_q, wr_q;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   // Full check uses the pre-pop count, so a pop frees the slot this cycle.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign dout_o  = mem_q[rd_q];

   always_comb begin
      count_d = count_q;
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q] <= din_i;
   end

   // Pointers are AW bits wide, so they wrap mod DEPTH on their own.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
         full_o  <= 1'b0;
         empty_o <= 1'b1;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
         count_q <= count_d;
         full_o  <= (count_d == FULL_CNT);
         empty_o <= (count_d == '0);
      end
   end

endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: queues bytes from a level-held request and sends them
// as 8N1 frames, LSB first.
//   clk_i, rst_i        - clock, async active-low reset
//   bus (slave)         - byte request in, FIFO status / overflow out
//   tx_o                - serial line, idles high (registered)
//   tx_active_o         - high from first start-bit cycle to last stop cycle
//   transmission_done_o - one-cycle pulse after each stop bit
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 234,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   uart_tx_serializer_if.slave  bus,
   output logic                 tx_o,
   output logic                 tx_active_o,
   output logic                 transmission_done_o
);

   localparam int                CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]     LAST_CNT = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]        LAST_IDX = 3'(UART_DATA_BITS - 1);

   tx_state_e                 state_q;
   logic [CW-1:0]             cnt_q;
   logic [2:0]                idx_q;
   logic [UART_DATA_BITS-1:0] shift_q;
   logic                      valid_q, overflow_q;
   logic                      push, pop;
   logic                      fifo_full, fifo_empty;
   logic [UART_DATA_BITS-1:0] fifo_dout;

   // One push per high period of the level request.
   assign push = bus.tx_data_valid && !valid_q;
   assign pop  = (state_q == IDLE) && !fifo_empty;

   assign bus.fifo_full  = fifo_full;
   assign bus.fifo_empty = fifo_empty;
   assign bus.overflow   = overflow_q;

   byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(UART_DATA_BITS)) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   (bus.tx_data),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         valid_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         valid_q    <= bus.tx_data_valid;
         overflow_q <= push && fifo_full && !pop;
      end
   end

   // Outputs are set on the transition into each state so they are
   // registered yet line up with the state they belong to.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q             <= IDLE;
         cnt_q               <= '0;
         idx_q               <= '0;
         shift_q             <= '0;
         tx_o                <= UART_LINE_IDLE;
         tx_active_o         <= 1'b0;
         transmission_done_o <= 1'b0;
      end else begin
         transmission_done_o <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (pop) begin
                  shift_q     <= fifo_dout;
                  cnt_q       <= '0;
                  tx_o        <= 1'b0;
                  tx_active_o <= 1'b1;
                  state_q     <= START;
               end
            end
            START: begin
               if (cnt_q == LAST_CNT) begin
                  cnt_q   <= '0;
                  idx_q   <= '0;
                  tx_o    <= shift_q[0];
                  state_q <= DATA;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DATA: begin
               if (cnt_q == LAST_CNT) begin
                  cnt_q <= '0;
                  if (idx_q == LAST_IDX) begin
                     tx_o    <= UART_LINE_IDLE;
                     state_q <= STOP;
                  end else begin
                     idx_q   <= idx_q + 1'b1;
                     shift_q <= shift_q >> 1;
                     tx_o    <= shift_q[1];
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            STOP: begin
               if (cnt_q == LAST_CNT) begin
                  cnt_q               <= '0;
                  tx_active_o         <= 1'b0;
                  transmission_done_o <= 1'b1;
                  state_q             <= DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               tx_o        <= UART_LINE_IDLE;
               tx_active_o <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench: every push is run through a timing model that decides
// acceptance and schedules the frame; expected bytes, start cycles, done
// pulses and overflow pulses are queued and popped by a negedge monitor.
module tb_uart_tx_serializer;

   localparam int C     = 4;
   localparam int D     = 4;
   localparam int FRAME = 10 * C;

   logic clk = 1'b0;
   logic rst_n;
   logic tx_o, tx_active, done;

   uart_tx_serializer_if bus();

   uart_tx_serializer #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
      .clk_i               (clk),
      .rst_i               (rst_n),
      .bus                 (bus),
      .tx_o                (tx_o),
      .tx_active_o         (tx_active),
      .transmission_done_o (done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0, n_pass = 0;

   // Reference model: accepted bytes with their push and pop cycles.
   int         m_push[$], m_pop[$];
   int         last_pop = -1000;
   logic [7:0] exp_bytes[$];
   int         exp_start[$], exp_done[$], exp_ovf[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
   endtask

   // Bytes resident in the FIFO during cycle m, before that cycle's pop.
   function automatic int model_count(input int m);
      int n = 0;
      foreach (m_push[i]) if (m_push[i] < m && m_pop[i] >= m) n++;
      return n;
   endfunction

   function automatic logic model_active(input int m);
      logic a = 1'b0;
      foreach (m_pop[i]) if (m >= m_pop[i] + 1 && m <= m_pop[i] + FRAME) a = 1'b1;
      return a;
   endfunction

   // Push detected in cycle n. Accepted if there is room, or if the head
   // leaves in the same cycle; the transmitter pops at most once per
   // FRAME+2 cycles and never before the cycle after the push.
   task automatic model_push(input logic [7:0] b, input int n);
      int  cnt = model_count(n);
      bit  popnow = 0;
      int  p;
      foreach (m_pop[i]) if (m_pop[i] == n) popnow = 1;
      if (cnt < D || popnow) begin
         p = (n + 1 > last_pop + FRAME + 2) ? n + 1 : last_pop + FRAME + 2;
         m_push.push_back(n);
         m_pop.push_back(p);
         last_pop = p;
         exp_bytes.push_back(b);
         exp_start.push_back(p + 1);
         exp_done.push_back(p + 1 + FRAME);
      end else begin
         exp_ovf.push_back(n + 1);
      end
   endtask

   task automatic model_reset();
      m_push.delete(); m_pop.delete();
      exp_bytes.delete(); exp_start.delete(); exp_done.delete(); exp_ovf.delete();
      last_pop = -1000;
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) begin @(posedge clk); #1; end
   endtask

   // Raise valid for `hold` cycles; data is scrambled after the push cycle.
   task automatic push_byte(input logic [7:0] b, input int hold);
      @(posedge clk); #1;
      bus.tx_data       = b;
      bus.tx_data_valid = 1'b1;
      model_push(b, cyc);
      repeat (hold) begin @(posedge clk); #1; bus.tx_data = 8'($urandom); end
      bus.tx_data_valid = 1'b0;
   endtask

   task automatic drain();
      wait_cyc(last_pop + FRAME + 4);
   endtask

   function automatic int next_pop(input int m);
      int t = 1 << 30;
      foreach (m_pop[i]) if (m_pop[i] > m && m_pop[i] < t) t = m_pop[i];
      return t;
   endfunction

   // Monitor: flags vs model each cycle, event queues, frame decoding.
   bit         mbusy = 0;
   int         mt = 0;
   int         mk;
   logic [7:0] mbyte;
   logic       prev_tx = 1'b1;

   always @(negedge clk) begin
      if (!rst_n) begin
         mbusy   = 0;
         prev_tx = 1'b1;
      end else begin
         chk("fifo_full",  bus.fifo_full,  model_count(cyc) == D);
         chk("fifo_empty", bus.fifo_empty, model_count(cyc) == 0);
         chk("tx_active",  tx_active,      model_active(cyc));
         if (exp_done.size() > 0 && exp_done[0] == cyc) begin
            chk("done_pulse", done, 1);
            void'(exp_done.pop_front());
         end else chk("done_quiet", done, 0);
         if (exp_ovf.size() > 0 && exp_ovf[0] == cyc) begin
            chk("overflow_pulse", bus.overflow, 1);
            void'(exp_ovf.pop_front());
         end else chk("overflow_quiet", bus.overflow, 0);
         if (exp_start.size() > 0 && exp_start[0] == cyc) begin
            chk("start_edge", {prev_tx, tx_o}, 2'b10);
            void'(exp_start.pop_front());
         end
         if (!mbusy) begin
            if (prev_tx && !tx_o) begin mbusy = 1; mt = 0; mbyte = '0; end
         end else mt++;
         if (mbusy && (mt % C) == C / 2) begin
            mk = mt / C;
            if (mk == 0) chk("start_bit", tx_o, 0);
            else if (mk <= 8) mbyte[3'(mk - 1)] = tx_o;
            else begin
               chk("stop_bit", tx_o, 1);
               chk("frame_expected", exp_bytes.size() > 0, 1);
               if (exp_bytes.size() > 0) chk("frame_byte", mbyte, exp_bytes.pop_front());
            end
         end
         if (mbusy && mt == FRAME - 1) mbusy = 0;
         prev_tx = tx_o;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: run exceeded its time limit at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t, s;
      logic [7:0] b;
      bus.tx_data       = '0;
      bus.tx_data_valid = 1'b0;
      rst_n             = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      chk("rst_tx",       tx_o,           1);
      chk("rst_active",   tx_active,      0);
      chk("rst_done",     done,           0);
      chk("rst_overflow", bus.overflow,   0);
      chk("rst_full",     bus.fifo_full,  0);
      chk("rst_empty",    bus.fifo_empty, 1);
      rst_n = 1'b1;

      // Single byte, long valid
      push_byte(8'hA5, 6);
      drain();

      // Back-to-back frames
      push_byte(8'h00, 2);
      push_byte(8'hFF, 2);
      push_byte(8'h55, 2);
      drain();
      chk("empty_after_drain", bus.fifo_empty, 1);

      // Overflow, then push exactly on the pop of a full FIFO
      push_byte(8'($urandom), 2);
      repeat (4) push_byte(8'($urandom), 2);
      chk("full_after_fill", bus.fifo_full, 1);
      push_byte(8'($urandom), 2);
      t = next_pop(cyc);
      wait_cyc(t - 1);
      push_byte(8'($urandom), 2);
      chk("full_after_simul", bus.fifo_full, 1);
      push_byte(8'($urandom), 2);
      drain();

      // Randomized traffic
      for (int i = 0; i < 12; i++) begin
         repeat ($urandom_range(0, 50)) begin @(posedge clk); #1; end
         push_byte(8'($urandom), int'($urandom_range(1, 4)));
      end
      drain();

      // Reset during DATA bit 3 with bytes queued
      push_byte(8'($urandom), 2);
      s = last_pop + 1;
      push_byte(8'($urandom), 2);
      push_byte(8'($urandom), 2);
      wait_cyc(s + 4 * C + 1);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("midrst_tx",     tx_o,           1);
      chk("midrst_empty",  bus.fifo_empty, 1);
      chk("midrst_active", tx_active,      0);
      chk("midrst_done",   done,           0);
      repeat (2) begin @(posedge clk); #1; end
      // Valid already high at release counts as a new request.
      b = 8'($urandom);
      bus.tx_data       = b;
      bus.tx_data_valid = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_push(b, cyc);
      repeat (2) begin @(posedge clk); #1; bus.tx_data = 8'($urandom); end
      bus.tx_data_valid = 1'b0;
      drain();
      push_byte(8'h3C, 2);
      drain();

      // Valid held for 200 cycles: one byte only
      push_byte(8'($urandom), 200);
      drain();
      repeat (4) begin @(posedge clk); #1; end

      chk("bytes_drained",    exp_bytes.size(), 0);
      chk("done_drained",     exp_done.size(),  0);
      chk("overflow_drained", exp_ovf.size(),   0);
      chk("start_drained",    exp_start.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
